bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Produces packed BCD digits, for example the 4-bit digit inputs of the board's 7-segment digit decoders, from binary results generated elsewhere in the processor.
- Uses a start/busy/done handshake.
- Output digits are registered and held stable between conversions, so display logic can read them at any time.

---
 rtl/bin_to_bcd_seq_pkg.sv | 13 +
 rtl/bin_to_bcd_seq_bcd_digit_adjust.sv | 19 +
 rtl/bin_to_bcd_seq.sv | 149 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0] ADJ_ADD       = 4'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_digit_adjust
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Add-3 correction, wrapping in 4 bits.
  always_comb begin
    dout = din;
    if (din >= ADJ_THRESHOLD) begin
      dout = din + ADJ_ADD;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a start/busy/done handshake and registered, held result digits.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam int                BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam int                SR_W     = BCD_W + WIDTH;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   bin_r;
  logic [BCD_W-1:0]   scratch_r;
  logic               ovf_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [BCD_W-1:0]   bcd_r;
  logic               overflow_r;
  logic               done_r;
  logic               busy_r;

  logic [BCD_W-1:0]   adj_s;
  logic [SR_W-1:0]    sr_s;
  logic [SR_W-1:0]    sr_shift_s;
  logic [BCD_W-1:0]   scratch_nxt_s;
  logic [WIDTH-1:0]   bin_nxt_s;
  logic               ovf_nxt_s;
  logic               last_bit_s;
  logic               accept_s;
  logic               complete_s;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .din  (scratch_r[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (adj_s[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Adjusted scratch and binary form one register shifted left as a whole.
  assign sr_s          = {adj_s, bin_r};
  assign sr_shift_s    = {sr_s[SR_W-2:0], 1'b0};
  assign scratch_nxt_s = sr_shift_s[SR_W-1 -: BCD_W];
  assign bin_nxt_s     = sr_shift_s[WIDTH-1:0];
  assign ovf_nxt_s     = ovf_r | sr_s[SR_W-1];

  assign last_bit_s = (cnt_r == LAST_CNT);
  assign accept_s   = (state_r == IDLE) && start;
  assign complete_s = (state_r == SHIFT) && last_bit_s;

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Conversion datapath: capture on accept, adjust-and-shift while in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r     <= '0;
      scratch_r <= '0;
      ovf_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            bin_r     <= bin;
            scratch_r <= '0;
            ovf_r     <= 1'b0;
            cnt_r     <= '0;
          end
        end
        SHIFT: begin
          bin_r     <= bin_nxt_s;
          scratch_r <= scratch_nxt_s;
          ovf_r     <= ovf_nxt_s;
          cnt_r     <= cnt_r + CNT_W'(1);
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Handshake and result registers; results only move on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      busy_r <= accept_s || ((state_r == SHIFT) && !last_bit_s);
      done_r <= complete_s;
      if (complete_s) begin
        bcd_r      <= scratch_nxt_s;
        overflow_r <= ovf_nxt_s;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd      = bcd_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and random self-checking bench for bin_to_bcd_seq (16-bit/5-digit and 8-bit/2-digit).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start16, start8;
  logic [15:0] bin16;
  logic [7:0]  bin8;
  logic        busy16, done16, ovf16;
  logic        busy8, done8, ovf8;
  logic [19:0] bcd16;
  logic [7:0]  bcd8;

  int compared = 0;
  int mism     = 0;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16), .overflow(ovf16)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for done after an accepted start; counts cycles, busy cycles and bcd stability.
  task automatic wait16(input logic [19:0] prev, output int lat, output int bc, output bit stable);
    lat = 0;
    bc = 0;
    stable = 1'b1;
    while (!done16 && lat < 40) begin
      if (busy16) bc++;
      if (bcd16 !== prev) stable = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic conv16(input logic [15:0] v, output int lat, output int bc, output bit stable);
    logic [19:0] prev;
    prev = bcd16;
    start16 = 1'b1;
    bin16 = v;
    tick();
    start16 = 1'b0;
    wait16(prev, lat, bc, stable);
  endtask

  task automatic conv8(input logic [7:0] v, output int lat);
    start8 = 1'b1;
    bin8 = v;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  initial begin
    int   lat, bc, ndone;
    bit   stable;
    logic [15:0] v;

    rst_n = 1'b0;
    start16 = 1'b0;
    start8 = 1'b0;
    bin16 = 16'd0;
    bin8 = 8'd0;
    tick();
    tick();
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_bcd", 32'(bcd16), 32'd0);
    chk("rst_ovf", 32'(ovf16), 32'd0);
    rst_n = 1'b1;
    tick();

    // Bounds
    conv16(16'd0, lat, bc, stable);
    chk("zero_lat", 32'(lat), 32'd16);
    chk("zero_bcd", 32'(bcd16), 32'h00000);
    tick();
    chk("zero_done_drop", 32'(done16), 32'd0);

    conv16(16'd65535, lat, bc, stable);
    chk("max_bcd", 32'(bcd16), 32'h65535);
    chk("max_ovf", 32'(ovf16), 32'd0);
    chk("max_digit4", 32'(bcd16[19:16]), 32'd6);
    tick();

    // Reset mid-conversion
    start16 = 1'b1;
    bin16 = 16'd12345;
    tick();
    start16 = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_bcd", 32'(bcd16), 32'd0);
    chk("midrst_busy", 32'(busy16), 32'd0);
    chk("midrst_done", 32'(done16), 32'd0);
    ndone = 0;
    repeat (3) begin
      tick();
      if (done16) ndone++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      if (done16) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    conv16(16'd12345, lat, bc, stable);
    chk("after_rst_lat", 32'(lat), 32'd16);
    chk("after_rst_bcd", 32'(bcd16), 32'h12345);
    chk("after_rst_ovf", 32'(ovf16), 32'd0);
    tick();

    // Busy protection
    start16 = 1'b1;
    bin16 = 16'd999;
    tick();
    start16 = 1'b0;
    tick();
    tick();
    start16 = 1'b1;
    bin16 = 16'd1;
    tick();
    start16 = 1'b0;
    wait16(20'h12345, lat, bc, stable);
    chk("busy_lat", 32'(lat + 3), 32'd16);
    chk("busy_cycles", 32'(bc + 3), 32'd16);
    chk("busy_bcd", 32'(bcd16), 32'h00999);
    chk("busy_stable", 32'(stable), 32'd1);
    ndone = 0;
    repeat (25) begin
      tick();
      if (done16) ndone++;
    end
    chk("busy_single_done", 32'(ndone), 32'd0);
    chk("busy_bcd_held", 32'(bcd16), 32'h00999);

    // Back-to-back
    conv16(16'd42, lat, bc, stable);
    chk("b2b_first_bcd", 32'(bcd16), 32'h00042);
    start16 = 1'b1;
    bin16 = 16'd7;
    tick();
    start16 = 1'b0;
    chk("b2b_done_drop", 32'(done16), 32'd0);
    chk("b2b_busy", 32'(busy16), 32'd1);
    chk("b2b_hold", 32'(bcd16), 32'h00042);
    wait16(20'h00042, lat, bc, stable);
    chk("b2b_gap", 32'(lat), 32'd16);
    chk("b2b_second_bcd", 32'(bcd16), 32'h00007);
    chk("b2b_stable", 32'(stable), 32'd1);
    tick();

    // Overflow on the 8-bit/2-digit instance
    conv8(8'd255, lat);
    chk("ov_lat", 32'(lat), 32'd8);
    chk("ov_bcd", 32'(bcd8), 32'h55);
    chk("ov_flag", 32'(ovf8), 32'd1);
    tick();
    conv8(8'd99, lat);
    chk("ov99_bcd", 32'(bcd8), 32'h99);
    chk("ov99_flag", 32'(ovf8), 32'd0);
    tick();
    conv8(8'd100, lat);
    chk("ov100_bcd", 32'(bcd8), 32'h00);
    chk("ov100_flag", 32'(ovf8), 32'd1);
    tick();

    // Random sweep against a division-based reference
    for (int n = 0; n < 1000; n++) begin
      v = 16'($urandom_range(0, 65535));
      conv16(v, lat, bc, stable);
      chk("rnd_bcd", 32'(bcd16), 32'(ref_bcd(int'(v))));
      chk("rnd_lat", 32'(lat), 32'd16);
      chk("rnd_stable", 32'(stable), 32'd1);
      tick();
      chk("rnd_done_pulse", 32'(done16), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
